// File: rtl/mips_prog_loader.sv
// Serial program loader: receives framed instruction words from a byte stream,
// writes them into instruction memory and releases the CPU after a good checksum.
module mips_prog_loader #(
    parameter int         ADDR_W    = 10,
    parameter int         BASE_ADDR = 0,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic              clk1,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              cpu_start,
    output logic              done,
    output logic              err,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COUNT = 3'd1,
        DATA  = 3'd2,
        CSUM  = 3'd3,
        START = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);

    state_t              state_q, state_d;
    logic [7:0]          count_q, count_d;
    logic [7:0]          word_idx_q, word_idx_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [31:0]         asm_q, asm_d;
    logic [7:0]          csum_q, csum_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                cpu_hold_q, cpu_hold_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                accept;
    logic [31:0]         asm_shift;
    logic                last_word;

    // Handshake: a byte transfers on a rising edge where rx_valid and rx_ready
    // are both high; rx_ready depends only on state, never on rx_valid.
    assign rx_ready  = (state_q != START);
    assign accept    = rx_valid && rx_ready;
    assign asm_shift = {asm_q[23:0], rx_data};
    assign last_word = ((word_idx_q + 8'd1) == count_q);

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign cpu_start = (state_q == START);
    assign done      = done_q;
    assign err       = err_q;
    assign state_dbg = state_q;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        word_idx_d  = word_idx_q;
        byte_cnt_d  = byte_cnt_q;
        asm_d       = asm_q;
        csum_d      = csum_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_hold_d  = cpu_hold_q;
        done_d      = done_q;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                if (accept && (rx_data == SYNC_BYTE)) begin
                    state_d    = COUNT;
                    cpu_hold_d = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                end
            end
            COUNT: begin
                if (accept) begin
                    if (rx_data == 8'd0) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        count_d    = rx_data;
                        word_idx_d = 8'd0;
                        byte_cnt_d = 2'd0;
                        csum_d     = 8'd0;
                        state_d    = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    asm_d      = asm_shift;
                    csum_d     = csum_q ^ rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    // Fourth byte completes a word: the write strobe lands next cycle.
                    if (byte_cnt_q == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_wdata_d = asm_shift;
                        mem_addr_d  = BASE_A + ADDR_W'(word_idx_q);
                        word_idx_d  = word_idx_q + 8'd1;
                        if (last_word) begin
                            state_d = CSUM;
                        end
                    end
                end
            end
            CSUM: begin
                if (accept) begin
                    if (rx_data == csum_q) begin
                        state_d    = START;
                        cpu_hold_d = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        err_d      = 1'b1;
                        cpu_hold_d = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            START: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk1) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= 8'd0;
            word_idx_q  <= 8'd0;
            byte_cnt_q  <= 2'd0;
            asm_q       <= 32'd0;
            csum_q      <= 8'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE_A;
            mem_wdata_q <= 32'd0;
            cpu_hold_q  <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            word_idx_q  <= word_idx_d;
            byte_cnt_q  <= byte_cnt_d;
            asm_q       <= asm_d;
            csum_q      <= csum_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_mips_prog_loader.sv
// Directed bench for mips_prog_loader: default instance plus a BASE_ADDR=1022
// instance for address wrap; memory writes and start pulses are logged at negedge.
module tb_mips_prog_loader;

    localparam logic [2:0] S_IDLE = 3'd0;

    logic        clk1 = 1'b0;
    logic        reset = 1'b1;

    logic        rx_valid = 1'b0, rx_valid_w = 1'b0;
    logic [7:0]  rx_data = 8'd0, rx_data_w = 8'd0;
    logic        rx_ready, rx_ready_w;
    logic        mem_we, mem_we_w;
    logic [9:0]  mem_addr, mem_addr_w;
    logic [31:0] mem_wdata, mem_wdata_w;
    logic        cpu_hold, cpu_hold_w;
    logic        cpu_start, cpu_start_w;
    logic        done, done_w;
    logic        err, err_w;
    logic [2:0]  state_dbg, state_dbg_w;

    int checks = 0;
    int errors = 0;

    logic [31:0] frame_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] wr_a_q[$], wr_d_q[$], wr_a_w_q[$], wr_d_w_q[$];
    int          start_cnt = 0, start_cnt_w = 0;
    logic        hold_at_start = 1'b1, done_at_start = 1'b0;

    mips_prog_loader #(.ADDR_W(10), .BASE_ADDR(0), .SYNC_BYTE(8'hA5)) dut (
        .clk1(clk1), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .cpu_start(cpu_start), .done(done), .err(err),
        .state_dbg(state_dbg)
    );

    mips_prog_loader #(.ADDR_W(10), .BASE_ADDR(1022), .SYNC_BYTE(8'hA5)) dut_w (
        .clk1(clk1), .reset(reset), .rx_valid(rx_valid_w), .rx_data(rx_data_w),
        .rx_ready(rx_ready_w), .mem_we(mem_we_w), .mem_addr(mem_addr_w), .mem_wdata(mem_wdata_w),
        .cpu_hold(cpu_hold_w), .cpu_start(cpu_start_w), .done(done_w), .err(err_w),
        .state_dbg(state_dbg_w)
    );

    // ---------------- clock ----------------
    always #5 clk1 = ~clk1;

    // ---------------- monitors ----------------
    always @(negedge clk1) begin
        if (mem_we) begin
            wr_a_q.push_back({22'd0, mem_addr});
            wr_d_q.push_back(mem_wdata);
        end
        if (mem_we_w) begin
            wr_a_w_q.push_back({22'd0, mem_addr_w});
            wr_d_w_q.push_back(mem_wdata_w);
        end
        if (cpu_start) begin
            start_cnt++;
            hold_at_start = cpu_hold;
            done_at_start = done;
        end
        if (cpu_start_w) start_cnt_w++;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_writes(input bit w, input int from, input int base, input int n);
        int got;
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(frame_q[i]);
        got = (w ? wr_a_w_q.size() : wr_a_q.size()) - from;
        check("write_count", got, n);
        for (int i = 0; i < n && i < got; i++) begin
            check("write_addr", w ? wr_a_w_q[from+i] : wr_a_q[from+i], (base + i) % 1024);
            check("write_data", w ? wr_d_w_q[from+i] : wr_d_q[from+i], exp_q[i]);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk1);
            #1;
        end
    endtask

    task automatic send_byte(input bit w, input logic [7:0] b, input int gap);
        int n;
        idle_cycles(gap);
        if (w) begin rx_valid_w = 1'b1; rx_data_w = b; end
        else   begin rx_valid   = 1'b1; rx_data   = b; end
        n = 0;
        while (!(w ? rx_ready_w : rx_ready) && n < 50) begin
            @(posedge clk1);
            #1;
            n++;
        end
        if (n >= 50) check("ready_timeout", n, 0);
        @(posedge clk1);
        #1;
        if (w) rx_valid_w = 1'b0;
        else   rx_valid   = 1'b0;
    endtask

    function automatic int pick_gap(input int max_gap);
        return (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap));
    endfunction

    task automatic send_frame(input bit w, input logic [7:0] csum, input int max_gap);
        logic [31:0] wd;
        send_byte(w, 8'hA5, pick_gap(max_gap));
        send_byte(w, 8'(frame_q.size()), pick_gap(max_gap));
        for (int i = 0; i < frame_q.size(); i++) begin
            wd = frame_q[i];
            for (int j = 0; j < 4; j++) send_byte(w, wd[31-8*j -: 8], pick_gap(max_gap));
        end
        send_byte(w, csum, pick_gap(max_gap));
    endtask

    task automatic load_program_words();
        frame_q = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
                    32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int from, starts;
        logic [31:0] wd;

        idle_cycles(3);
        reset = 1'b0;
        #1;
        check("rst_hold", cpu_hold, 1);
        check("rst_start", cpu_start, 0);
        check("rst_we", mem_we, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_ready", rx_ready, 1);
        check("rst_state", state_dbg, S_IDLE);
        check("rst_addr_wrap_inst", mem_addr_w, 1022);

        // Program load with good checksum
        load_program_words();
        from = wr_a_q.size(); starts = start_cnt;
        send_frame(0, 8'hE9, 0);
        check("load_ready_in_start", rx_ready, 0);
        idle_cycles(3);
        check_writes(0, from, 0, 9);
        check("load_start_pulses", start_cnt - starts, 1);
        check("load_hold_at_start", hold_at_start, 0);
        check("load_done_at_start", done_at_start, 1);
        check("load_hold", cpu_hold, 0);
        check("load_done", done, 1);
        check("load_err", err, 0);
        check("load_state", state_dbg, S_IDLE);

        // Same frame, bad checksum
        from = wr_a_q.size(); starts = start_cnt;
        send_frame(0, 8'hE8, 0);
        idle_cycles(3);
        check_writes(0, from, 0, 9);
        check("badcs_start_pulses", start_cnt - starts, 0);
        check("badcs_hold", cpu_hold, 1);
        check("badcs_err", err, 1);
        check("badcs_done", done, 0);
        check("badcs_we_idle", mem_we, 0);
        check("badcs_addr_held", mem_addr, 8);
        check("badcs_wdata_held", mem_wdata, 32'hfc000000);

        // Zero count, then a good one-word frame
        from = wr_a_q.size(); starts = start_cnt;
        send_byte(0, 8'hA5, 0);
        send_byte(0, 8'h00, 0);
        idle_cycles(2);
        check("zero_writes", wr_a_q.size() - from, 0);
        check("zero_err", err, 1);
        check("zero_state", state_dbg, S_IDLE);
        check("zero_hold", cpu_hold, 1);
        frame_q = '{32'h12345678};
        send_frame(0, 8'h08, 0);
        idle_cycles(3);
        check_writes(0, from, 0, 1);
        check("zero_then_good_err", err, 0);
        check("zero_then_good_done", done, 1);
        check("zero_then_good_start", start_cnt - starts, 1);

        // Noise bytes and random valid gaps
        from = wr_a_q.size(); starts = start_cnt;
        send_byte(0, 8'h00, pick_gap(3));
        send_byte(0, 8'hFF, pick_gap(3));
        send_byte(0, 8'h5A, pick_gap(3));
        frame_q = '{32'h12345678};
        send_frame(0, 8'h08, 3);
        idle_cycles(3);
        check_writes(0, from, 0, 1);
        check("noise_start", start_cnt - starts, 1);
        check("noise_hold", cpu_hold, 0);
        check("noise_err", err, 0);

        // Address wrap on the BASE_ADDR=1022 instance
        frame_q = '{32'hdeadbeef, 32'h01020304, 32'hcafef00d};
        from = wr_a_w_q.size(); starts = start_cnt_w;
        send_frame(1, 8'hEF, 1);
        idle_cycles(3);
        check_writes(1, from, 1022, 3);
        check("wrap_start", start_cnt_w - starts, 1);
        check("wrap_err", err_w, 0);

        // Reset after byte 2 of word 3
        load_program_words();
        from = wr_a_q.size(); starts = start_cnt;
        send_byte(0, 8'hA5, 0);
        send_byte(0, 8'h09, 0);
        for (int i = 0; i < 2; i++) begin
            wd = frame_q[i];
            for (int j = 0; j < 4; j++) send_byte(0, wd[31-8*j -: 8], 0);
        end
        send_byte(0, 8'h28, 0);
        send_byte(0, 8'h03, 0);
        reset = 1'b1;
        idle_cycles(1);
        reset = 1'b0;
        check("midrst_state", state_dbg, S_IDLE);
        check("midrst_hold", cpu_hold, 1);
        check("midrst_addr", mem_addr, 0);
        idle_cycles(5);
        check_writes(0, from, 0, 2);
        check("midrst_we", mem_we, 0);
        check("midrst_no_start", start_cnt - starts, 0);
        frame_q = '{32'h12345678};
        from = wr_a_q.size();
        send_frame(0, 8'h08, 0);
        idle_cycles(3);
        check_writes(0, from, 0, 1);
        check("midrst_good_done", done, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_prog_loader.md
MIPS_PROG_LOADER -- requirements
Module: mips_prog_loader

Interface
REQ-001 Parameter ADDR_W, default 10, instruction-memory word-address width.
REQ-002 Parameter BASE_ADDR, default 0, word address of the first loaded instruction.
REQ-003 Parameter SYNC_BYTE, default 8'hA5, frame header byte.
REQ-004 clk1  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  reset, synchronous and active-high.
REQ-006 rx_valid  input  1  byte-stream valid.
REQ-007 rx_data  input  8  byte-stream data.
REQ-008 rx_ready  output  1  loader can accept a byte this cycle.
REQ-009 mem_we  output  1  one-cycle instruction-memory write strobe.
REQ-010 mem_addr  output  ADDR_W  instruction-memory word address.
REQ-011 mem_wdata  output  32  instruction word to write.
REQ-012 cpu_hold  output  1  holds the CPU halted (HALTED=1) while high.
REQ-013 cpu_start  output  1  one-cycle pulse; the CPU clears PC and TAKEN_BRANCH and runs.
REQ-014 done  output  1  last frame loaded with a good checksum.
REQ-015 err  output  1  last frame rejected (bad count or checksum).

Function
REQ-016 A byte SHALL be accepted only in a cycle where rx_valid and rx_ready are both 1.
REQ-017 Frame format: SYNC_BYTE, count N (words, 1..255), 4*N data bytes with each word MSB first, then a checksum byte equal to the XOR of all data bytes.
REQ-018 The FSM SHALL have the states IDLE, COUNT, DATA, CSUM and START.
REQ-019 In IDLE, non-SYNC bytes SHALL be accepted and discarded; an accepted SYNC byte moves the FSM to COUNT, sets cpu_hold=1, and clears done and err.
REQ-020 In COUNT, N=0 SHALL set err=1 and return the FSM to IDLE; otherwise the FSM captures N, clears the word index and checksum, and goes to DATA.
REQ-021 In DATA, data bytes SHALL be shifted into a 32-bit assembly register, MSB first, and XORed into the running checksum.
REQ-022 The cycle after the 4th byte of a word is accepted, mem_we SHALL be 1 for exactly one cycle, with mem_wdata = the assembled word and mem_addr = (BASE_ADDR + word index) mod 2^ADDR_W.
REQ-023 The word index SHALL increment after each write; the address wraps modulo 2^ADDR_W without error.
REQ-024 After N words, the FSM SHALL go to CSUM.
REQ-025 In CSUM, an accepted byte equal to the running checksum SHALL move the FSM to START; a mismatch SHALL set err=1, keep cpu_hold=1, and return the FSM to IDLE.
REQ-026 In START, for one cycle: cpu_start=1, cpu_hold=0, done=1, rx_ready=0; then the FSM returns to IDLE.
REQ-027 rx_ready SHALL be 1 in IDLE, COUNT, DATA and CSUM, and 0 in START.
REQ-028 Gaps in rx_valid SHALL stall the FSM without loss of state.
REQ-029 Back-to-back words SHALL be supported: a new byte may be accepted in the same cycle mem_we is high.
REQ-030 Words already written before an error SHALL remain in memory; the CPU stays held until a good frame completes.
REQ-031 Between frames, mem_we SHALL be 0 and mem_addr and mem_wdata SHALL hold their last values.

Reset
REQ-032 When reset=1 at a clk1 edge, the block SHALL enter IDLE with cpu_hold=1, cpu_start=0, mem_we=0, done=0, err=0, mem_addr=BASE_ADDR, mem_wdata=0, and the word index, checksum and assembly register cleared.
REQ-033 Reset SHALL take priority over every other event, including mid-frame and in START; a partial frame is abandoned and no further writes occur.

Verification
REQ-034 Program load: send A5, 09, then the nine words 2801000a, 28020014, 28030019, 0ce77800, 0ce77800, 00222000, 0ce77800, 00832800, fc000000, then E9 -> nine mem_we pulses at addresses 0..8 with those words, one cpu_start pulse, cpu_hold=0, done=1, err=0.
REQ-035 Bad checksum: the same frame ending with E8 -> nine writes, no cpu_start, cpu_hold=1, err=1, done=0.
REQ-036 Zero count: send A5, 00 -> no writes, err=1, FSM back in IDLE; a following good frame loads normally and clears err.
REQ-037 Noise and stalls: send 00, FF, 5A before A5, 01, 12, 34, 56, 78, 08, with random rx_valid gaps -> garbage ignored, a single write of 12345678 at address 0, then cpu_start.
REQ-038 Wrap: with BASE_ADDR=1022 and ADDR_W=10, send a 3-word frame -> writes at addresses 1022, 1023, 0.
REQ-039 Reset mid-DATA: assert reset after byte 2 of word 3 -> no further mem_we, cpu_hold=1, FSM in IDLE; a following good frame restarts at BASE_ADDR.
